// File: rtl/ro_trng_pkg.sv
// Shared types and helpers for the RO-TRNG oscillator sequencer.
package ro_trng_pkg;

  localparam int unsigned MaxRo   = 64;
  localparam int unsigned MaxSelW = 6;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDwell  = 2'd2,
    StSwitch = 2'd3
  } ro_state_e;

  typedef enum logic [1:0] {
    ModeScan  = 2'd0,
    ModeFixed = 2'd1,
    ModeMask  = 2'd2
  } ro_mode_e;

  // Reserved encoding 3 behaves as scan.
  function automatic ro_mode_e norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? ModeScan : ro_mode_e'(m);
  endfunction

  function automatic logic [MaxRo-1:0] onehot_low(input logic [MaxSelW-1:0] idx);
    logic [MaxRo-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/ro_next_sel.sv
// Circular next-set-bit finder: first set mask bit strictly after cur, wrapping to cur itself.
module ro_next_sel #(
  parameter int unsigned NUM_RO = 32,
  parameter int unsigned SEL_W  = $clog2(NUM_RO)
) (
  input  logic [NUM_RO-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o
);

  logic [SEL_W:0] cand;

  always_comb begin
    next_o  = cur_i;
    found_o = |mask_i;
    cand    = '0;
    // Walk from the farthest offset down so the nearest set bit wins.
    for (int k = int'(NUM_RO); k >= 1; k--) begin
      cand = {1'b0, cur_i} + (SEL_W + 1)'(k);
      if (cand >= (SEL_W + 1)'(NUM_RO)) begin
        cand = cand - (SEL_W + 1)'(NUM_RO);
      end
      if (mask_i[cand[SEL_W-1:0]]) begin
        next_o = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ro_sequencer.sv
// Ring-oscillator sequencer: walks a one-hot active-low enable bus through settle and dwell
// windows, strobing the sampler at the end of each dwell.
module ro_sequencer
  import ro_trng_pkg::*;
#(
  parameter int unsigned NUM_RO     = 32,
  parameter int unsigned SEL_W      = $clog2(NUM_RO),
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ro_enable_i,
  input  logic [1:0]         mode_i,
  input  logic [SEL_W-1:0]   fixed_sel_i,
  input  logic [NUM_RO-1:0]  mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [NUM_RO-1:0]  enable_o,
  output logic [SEL_W-1:0]   ctrl_o,
  output logic               sample_valid_o,
  output logic [SEL_W-1:0]   sample_idx_o,
  output logic               wrap_o,
  output logic               busy_o,
  output logic               cfg_err_o
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CntW    = (DWELL_W > SettleW) ? DWELL_W : SettleW;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);

  ro_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]    ctrl_q, ctrl_d;
  logic [NUM_RO-1:0]   enable_q, enable_d;
  ro_mode_e            mode_q, mode_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [SEL_W-1:0]    fixed_sel_q, fixed_sel_d;
  logic [NUM_RO-1:0]   mask_q, mask_d;
  logic                cfg_err_q;

  ro_mode_e            live_mode;
  logic                live_illegal;
  logic                cfg_illegal;
  logic [NUM_RO-1:0]   find_mask;
  logic [SEL_W-1:0]    next_idx;
  logic                next_found;
  logic [DWELL_W-1:0]  dwell_m1;
  logic                dwell_last;
  logic                capture;
  logic                wrap;

  assign live_mode    = norm_mode(mode_i);
  assign live_illegal = ((live_mode == ModeMask) && (mask_i == '0)) ||
                        (32'(fixed_sel_i) >= NUM_RO);
  assign dwell_m1     = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  // In IDLE the finder resolves the masked start index from live inputs; in SWITCH it
  // steps through the captured configuration. Scan uses an all-ones mask.
  always_comb begin
    find_mask = '1;
    if (state_q == StIdle) begin
      if (live_mode == ModeMask) find_mask = mask_i;
    end else if (mode_q == ModeMask) begin
      find_mask = mask_q;
    end
  end

  ro_next_sel #(
    .NUM_RO (NUM_RO),
    .SEL_W  (SEL_W)
  ) u_next_sel (
    .mask_i  (find_mask),
    .cur_i   (ctrl_q),
    .next_o  (next_idx),
    .found_o (next_found)
  );

  assign cfg_illegal = !next_found || (32'(fixed_sel_q) >= NUM_RO);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    mode_d      = mode_q;
    dwell_d     = dwell_q;
    fixed_sel_d = fixed_sel_q;
    mask_d      = mask_q;
    capture     = 1'b0;
    wrap        = 1'b0;
    dwell_last  = (state_q == StDwell) && (cnt_q == CntW'(dwell_m1));

    if (!ro_enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!live_illegal) begin
            state_d = StSettle;
            cnt_d   = '0;
            capture = 1'b1;
            case (live_mode)
              ModeFixed: ctrl_d = fixed_sel_i;
              ModeMask:  ctrl_d = mask_i[ctrl_q] ? ctrl_q : next_idx;
              default:   ctrl_d = ctrl_q;
            endcase
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_d = StDwell;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDwell: begin
          if (dwell_last) begin
            capture = 1'b1;
            cnt_d   = '0;
            // Same fixed index again: keep the RO running rather than break it.
            if ((live_mode == ModeFixed) && (fixed_sel_i == ctrl_q)) begin
              state_d = StDwell;
            end else begin
              state_d = StSwitch;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSwitch: begin
          cnt_d = '0;
          if (cfg_illegal) begin
            state_d = StIdle;
          end else begin
            state_d = StSettle;
            ctrl_d  = (mode_q == ModeFixed) ? fixed_sel_q : next_idx;
            wrap    = (mode_q != ModeFixed) && (next_idx <= ctrl_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (capture) begin
      mode_d      = live_mode;
      dwell_d     = dwell_i;
      fixed_sel_d = fixed_sel_i;
      mask_d      = mask_i;
    end

    enable_d = '1;
    if ((state_d == StSettle) || (state_d == StDwell)) begin
      enable_d = NUM_RO'(onehot_low(MaxSelW'(ctrl_d)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      enable_q    <= '1;
      mode_q      <= ModeScan;
      dwell_q     <= '0;
      fixed_sel_q <= '0;
      mask_q      <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      dwell_q     <= dwell_d;
      fixed_sel_q <= fixed_sel_d;
      mask_q      <= mask_d;
      cfg_err_q   <= live_illegal;
    end
  end

  assign enable_o       = enable_q;
  assign ctrl_o         = ctrl_q;
  assign sample_valid_o = dwell_last;
  assign sample_idx_o   = dwell_last ? ctrl_q : '0;
  assign wrap_o         = wrap;
  assign busy_o         = (state_q != StIdle);
  assign cfg_err_o      = cfg_err_q;

endmodule
